// File: rtl/ifu_fetch_if.sv
// Signal bundle between the fetch stage, instruction memory and the execution unit.
// The master view belongs to ifu_fetch; the slave view to its environment.
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    // instruction memory request/response
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            imem_rerr;

    // instruction hand-off to execute, and control coming back from it
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] dnpc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    // status
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;
    logic [63:0]     fetch_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata, imem_rerr,
        output inst_valid, inst, pc,
        input  inst_ready, dnpc, redirect, redirect_pc,
        output fetch_fault, fault_pc, fetch_cnt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata, imem_rerr,
        input  inst_valid, inst, pc,
        output inst_ready, dnpc, redirect, redirect_pc,
        input  fetch_fault, fault_pc, fetch_cnt
    );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch stage: owns the architectural pc, fetches one word
// per instruction and hands {inst, pc} to execute; redirects override pc at any time.
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [63:0]     cnt_q, cnt_d;
    logic            commit;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    assign commit = (state_q == S_HOLD) && bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        inst_d     = inst_q;
        cnt_d      = cnt_q;

        // A committed instruction is counted even if a redirect discards its dnpc.
        if (commit) begin
            cnt_d = cnt_q + 64'd1;
        end

        if (bus.redirect) begin
            pc_d = bus.redirect_pc;
            unique case (state_q)
                // A granted request still owes a response that must be drained.
                S_REQ:   state_d = bus.imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = bus.imem_rvalid ? S_REQ  : S_DROP;
                S_DROP:  state_d = bus.imem_rvalid ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
            // A misaligned target inside DROP is caught when the drain completes.
            if (state_d == S_REQ && misaligned(bus.redirect_pc)) begin
                state_d    = S_FAULT;
                fault_pc_d = bus.redirect_pc;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (bus.imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.imem_rerr) begin
                            state_d    = S_FAULT;
                            fault_pc_d = pc_q;
                        end else begin
                            state_d = S_HOLD;
                            inst_d  = bus.imem_rdata;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.inst_ready) begin
                        pc_d = bus.dnpc;
                        if (misaligned(bus.dnpc)) begin
                            state_d    = S_FAULT;
                            fault_pc_d = bus.dnpc;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid) begin
                        if (misaligned(pc_q)) begin
                            state_d    = S_FAULT;
                            fault_pc_d = pc_q;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            inst_q     <= 32'h0;
            cnt_q      <= 64'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
        end
    end

    // Request is held low while reset is applied so nothing is issued during the reset cycle.
    assign bus.imem_req    = rst && (state_q == S_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.inst_valid  = (state_q == S_HOLD);
    assign bus.inst        = inst_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_fault = (state_q == S_FAULT);
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed plus randomized bench for ifu_fetch; the bench plays memory and execute unit
// and tracks the expected architectural state with a transaction-level model.
module tb_ifu_fetch;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(XLEN)) bus ();

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // expected architectural state
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic [63:0] m_fault_pc;
    logic [31:0] m_inst;
    bit          m_fault;
    logic [31:0] mem [logic [63:0]];

    function automatic logic [31:0] word_at(input logic [63:0] addr);
        if (!mem.exists(addr)) mem[addr] = $urandom;
        return mem[addr];
    endfunction

    function automatic logic [63:0] rand_aligned();
        logic [31:0] lo;
        lo = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
        return {32'h0, lo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rerr   = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
    endtask

    // Checks after any transition that leaves no instruction on offer.
    task automatic check_after(input string tag);
        chk({tag, "_fault"}, bus.fetch_fault, m_fault);
        chk({tag, "_valid"}, bus.inst_valid, 1'b0);
        chk({tag, "_cnt"}, bus.fetch_cnt, m_cnt);
        chk({tag, "_inst"}, bus.inst, m_inst);
        if (m_fault) begin
            chk({tag, "_fault_pc"}, bus.fault_pc, m_fault_pc);
            chk({tag, "_req_off"}, bus.imem_req, 1'b0);
        end else begin
            chk({tag, "_req"}, bus.imem_req, 1'b1);
            chk({tag, "_addr"}, bus.imem_addr, m_pc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, bus.imem_req, 1'b0);
        chk({tag, "_valid"}, bus.inst_valid, 1'b0);
        chk({tag, "_inst"}, bus.inst, 32'h0);
        chk({tag, "_pc"}, bus.pc, RESET_PC);
        chk({tag, "_fault"}, bus.fetch_fault, 1'b0);
        chk({tag, "_fault_pc"}, bus.fault_pc, 64'h0);
        chk({tag, "_cnt"}, bus.fetch_cnt, 64'h0);
    endtask

    // Request phase: gd cycles without grant, then grant.
    task automatic issue(input int gd);
        for (int i = 0; i < gd; i++) begin
            chk("req_pending", bus.imem_req, 1'b1);
            chk("addr_stable", bus.imem_addr, m_pc);
            step();
        end
        chk("req", bus.imem_req, 1'b1);
        chk("addr", bus.imem_addr, m_pc);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
    endtask

    // Response phase: rd idle cycles, then a one-cycle rvalid.
    task automatic respond(input int rd, input bit err);
        logic [31:0] w;
        for (int i = 0; i < rd; i++) begin
            chk("wait_req_off", bus.imem_req, 1'b0);
            chk("wait_valid_off", bus.inst_valid, 1'b0);
            step();
        end
        w = word_at(m_pc);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = w;
        bus.imem_rerr   = err;
        step();
        clear_inputs();
        if (err) begin
            m_fault    = 1'b1;
            m_fault_pc = m_pc;
            check_after("bus_err");
        end else begin
            m_inst = w;
            chk("hold_valid", bus.inst_valid, 1'b1);
            chk("hold_inst", bus.inst, m_inst);
            chk("hold_pc", bus.pc, m_pc);
            chk("hold_req_off", bus.imem_req, 1'b0);
            chk("hold_fault", bus.fetch_fault, 1'b0);
        end
    endtask

    task automatic do_commit(input int hd, input logic [63:0] dn,
                             input bit redir, input logic [63:0] rpc);
        for (int i = 0; i < hd; i++) begin
            chk("stall_valid", bus.inst_valid, 1'b1);
            chk("stall_inst", bus.inst, m_inst);
            chk("stall_pc", bus.pc, m_pc);
            chk("stall_req_off", bus.imem_req, 1'b0);
            step();
        end
        bus.inst_ready  = 1'b1;
        bus.dnpc        = dn;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        step();
        clear_inputs();
        m_cnt = m_cnt + 64'd1;
        m_pc  = redir ? rpc : dn;
        if (m_pc[1:0] != 2'b00) begin
            m_fault    = 1'b1;
            m_fault_pc = m_pc;
        end
        check_after("commit");
    endtask

    // Redirect while no response is owed (REQ without grant, or FAULT).
    task automatic do_redirect(input logic [63:0] rpc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = rpc;
        step();
        clear_inputs();
        m_pc = rpc;
        if (rpc[1:0] != 2'b00) begin
            m_fault    = 1'b1;
            m_fault_pc = rpc;
        end else begin
            m_fault = 1'b0;
        end
        check_after("redirect");
    endtask

    // Redirect while the granted response is still outstanding; the response must vanish.
    task automatic redirect_in_wait(input logic [63:0] rpc, input bit coincide, input int jd);
        bus.redirect    = 1'b1;
        bus.redirect_pc = rpc;
        if (coincide) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        step();
        clear_inputs();
        if (!coincide) begin
            for (int i = 0; i < jd; i++) begin
                chk("drop_req_off", bus.imem_req, 1'b0);
                chk("drop_valid_off", bus.inst_valid, 1'b0);
                step();
            end
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            step();
            clear_inputs();
        end
        m_pc = rpc;
        check_after("drop");
    endtask

    initial begin
        int r;
        clear_inputs();
        bus.dnpc        = '0;
        bus.redirect_pc = '0;
        mem[RESET_PC]   = 32'h0000_0013;
        m_pc       = RESET_PC;
        m_cnt      = 64'd0;
        m_fault_pc = 64'd0;
        m_inst     = 32'h0;
        m_fault    = 1'b0;

        rst = 1'b0;
        repeat (3) step();
        check_reset_values("reset");

        // reset release with grant in the same cycle, response the next
        rst = 1'b1;
        #1;
        issue(0);
        respond(0, 1'b0);
        chk("first_inst", bus.inst, 32'h0000_0013);

        // stall then commit to 0x80000010
        do_commit(5, 64'h8000_0010, 1'b0, 64'h0);
        chk("cnt_one", bus.fetch_cnt, 64'd1);

        // redirect during WAIT; late response discarded
        issue(1);
        redirect_in_wait(64'h8000_0100, 1'b0, 2);
        issue(0);
        respond(1, 1'b0);

        // misaligned dnpc faults; fault is sticky until redirect
        do_commit(0, 64'h8000_0002, 1'b0, 64'h0);
        step();
        check_after("fault_sticky");
        do_redirect(64'h8000_0200);
        issue(0);
        respond(0, 1'b0);

        // bus error at 0x80000008
        do_commit(1, 64'h8000_0008, 1'b0, 64'h0);
        issue(0);
        respond(2, 1'b1);
        chk("err_fault_pc", bus.fault_pc, 64'h8000_0008);
        do_redirect(64'h8000_0300);

        // redirect coinciding with commit: counted, redirect target wins
        issue(0);
        respond(0, 1'b0);
        do_commit(0, 64'h8000_0400, 1'b1, 64'h8000_0500);

        // redirect coinciding with the response
        issue(0);
        redirect_in_wait(64'h8000_0600, 1'b1, 0);

        // reset mid-WAIT, then a stale response while requesting
        issue(0);
        rst = 1'b0;
        step();
        check_reset_values("reset_mid");
        rst = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        m_pc = RESET_PC; m_cnt = 64'd0; m_inst = 32'h0; m_fault = 1'b0; m_fault_pc = 64'd0;
        check_after("stale_rvalid");
        issue(0);
        respond(0, 1'b0);
        chk("restart_inst", bus.inst, 32'h0000_0013);
        do_commit(0, 64'h8000_0004, 1'b0, 64'h0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            issue($urandom_range(0, 2));
            if (r == 0) begin
                redirect_in_wait(rand_aligned(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end else if (r == 1) begin
                respond($urandom_range(0, 2), 1'b1);
                do_redirect(rand_aligned());
            end else begin
                respond($urandom_range(0, 2), 1'b0);
                if (r == 2)
                    do_commit($urandom_range(0, 3), rand_aligned() | 64'($urandom_range(1, 3)),
                              1'b0, 64'h0);
                else
                    do_commit($urandom_range(0, 3), rand_aligned(), r == 3, rand_aligned());
                if (m_fault) do_redirect(rand_aligned());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
